router_pe_rx: RTL and testbench
===============================

ROUTER_PE_RX -- requirements
Module: router_pe_rx

Interface
REQ-001 Parameters (name, default, meaning): DEPTH, 32, payload FIFO entries (power of two, 16-256).
REQ-002 SKID, 8, FIFO entries held in reserve for words still in flight after RX_BP asserts.
REQ-003 Ports (name, direction, width, meaning): CLK  in  1  clock.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 RX_D  in  64  word from router output port Q.
REQ-006 RX_VALID  in  1  RX_D valid this cycle.
REQ-007 RX_SOF  in  1  start-of-frame strobe from router Q_SOF.
REQ-008 RX_BP  out  1  backpressure to router Q_BP.
REQ-009 HDR_Q  out  64  last accepted header word.
REQ-010 HDR_STB  out  1  one-cycle pulse: HDR_Q updated.
REQ-011 P_DATA  out  64  payload word; P_LAST  out  1  final word of frame.
REQ-012 P_VALID  out  1; P_READY  in  1  payload valid/ready handshake.
REQ-013 FRAME_CNT  out  16  frames completed; ERR_CNT  out  16  frames aborted; OVF  out  1  sticky overflow.

Function
REQ-014 Word type is RX_D[63:56]: 8'h01 header, 8'h00 length word (payload count N in RX_D[31:0]), any other value illegal.
REQ-015 States: IDLE, HDR, PLD; all transitions occur only on cycles with RX_VALID=1, except RX_SOF handling.
REQ-016 IDLE/HDR, type 01: HDR_Q<=RX_D, HDR_STB=1 next cycle, state->HDR.
REQ-017 IDLE/HDR, type 00, N>0: load 32-bit TOGO<=N, state->PLD; length word not written to FIFO.
REQ-018 IDLE/HDR, type 00, N=0: FRAME_CNT+1, state->IDLE, nothing written to FIFO.
REQ-019 IDLE/HDR, illegal type: word dropped, ERR_CNT+1, state->IDLE.
REQ-020 PLD: each valid word written to FIFO as {last,data}, last=(TOGO==1); TOGO decrements by 1.
REQ-021 PLD with TOGO==1 and RX_VALID: FRAME_CNT+1, state->IDLE.
REQ-022 RX_SOF while in PLD: ERR_CNT+1, TOGO<=0, state->IDLE; RX_VALID on the same cycle is processed as an IDLE word; last already-queued word of the aborted frame is not re-marked.
REQ-023 RX_SOF in IDLE or HDR: no effect.
REQ-024 FIFO write when full: word dropped, OVF<=1 until RST; TOGO/state still advance.
REQ-025 RX_BP = registered (occupancy >= DEPTH-SKID); asserts 1 cycle after threshold reached, deasserts 1 cycle after occupancy drops below it.
REQ-026 FIFO is first-word-fall-through: P_VALID=1 whenever occupancy>0; pop on P_VALID&P_READY; P_DATA/P_LAST stable while P_VALID&~P_READY.
REQ-027 Simultaneous push and pop: occupancy unchanged; push into full FIFO with concurrent pop is accepted (no overflow).
REQ-028 Write-to-read latency: word accepted on cycle t visible on P_DATA at cycle t+1.
REQ-029 FRAME_CNT and ERR_CNT wrap 16'hFFFF -> 0.
REQ-030 HDR_STB is a single-cycle pulse per header word; header words never enter the FIFO and are not backpressured.

Reset
REQ-031 RST in any state, same clock edge: state IDLE, TOGO=0, FIFO empty, pointers 0.
REQ-032 Outputs after reset: RX_BP=0, P_VALID=0, P_LAST=0, HDR_STB=0, HDR_Q=0, P_DATA=0, FRAME_CNT=0, ERR_CNT=0, OVF=0.
REQ-033 RST overrides RX_VALID, RX_SOF and P_READY on the same cycle.

Verification
REQ-034 Headers 0x0100_0000_0000_00AA, 0x0100_0000_0000_00BB, length 0x0000_0000_0000_0003, payload D0..D2, P_READY=1 -> two HDR_STB pulses with HDR_Q AA then BB; P_DATA D0,D1,D2 with P_LAST only on D2; FRAME_CNT=1.
REQ-035 Length word N=0 -> no P_VALID, FRAME_CNT=1, state IDLE.
REQ-036 N=5, RX_SOF after 2 payload words, then a fresh frame N=1 -> ERR_CNT=1, FRAME_CNT=1, 3 words output, P_LAST only on the fresh frame word.
REQ-037 DEPTH=32, SKID=8, P_READY=0, N=40 streamed back-to-back ignoring RX_BP -> RX_BP=1 from the cycle after 24th write; 32 words stored, 8 dropped, OVF=1, FRAME_CNT=1.
REQ-038 Word 0x0200_0000_0000_0000 in IDLE -> ERR_CNT=1, no HDR_STB, no FIFO write.
REQ-039 RST asserted mid-payload (TOGO=4, FIFO holds 3) -> next cycle P_VALID=0, RX_BP=0, counters 0; following frame N=2 decoded normally.

Source files
------------

// File: rtl/router_pe_rx.sv
// router_pe_rx: receive side of a processing element attached to a router
// output port. Decodes header / length / payload words, publishes the most
// recent header, queues payload words in a first-word-fall-through FIFO and
// raises backpressure when only SKID free entries remain.
//
// Ports
//   CLK, RST             clock, synchronous active-high reset
//   RX_D, RX_VALID       incoming word and its valid strobe
//   RX_SOF               start-of-frame strobe (aborts a frame in payload)
//   RX_BP                backpressure to the router
//   HDR_Q, HDR_STB       last accepted header word, one-cycle update pulse
//   P_DATA, P_LAST       payload word at FIFO head, final-word flag
//   P_VALID, P_READY     payload handshake
//   FRAME_CNT, ERR_CNT   completed / aborted frame counters (wrapping)
//   OVF                  sticky FIFO overflow flag
module router_pe_rx #(
  parameter int DEPTH = 32,
  parameter int SKID  = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [63:0] RX_D,
  input  logic        RX_VALID,
  input  logic        RX_SOF,
  output logic        RX_BP,
  output logic [63:0] HDR_Q,
  output logic        HDR_STB,
  output logic [63:0] P_DATA,
  output logic        P_LAST,
  output logic        P_VALID,
  input  logic        P_READY,
  output logic [15:0] FRAME_CNT,
  output logic [15:0] ERR_CNT,
  output logic        OVF
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] BP_LVL   = CW'(DEPTH - SKID);
  localparam logic [7:0]    TYPE_HDR = 8'h01;
  localparam logic [7:0]    TYPE_LEN = 8'h00;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PLD} state_t;

  state_t      state_reg, state_next, eff_state;
  logic [31:0] togo_reg, togo_next;
  logic        abort;
  logic [7:0]  word_type;
  logic [31:0] word_len;

  logic hdr_load, push_req, push_last, frame_inc, illegal_word;

  assign word_type = RX_D[63:56];
  assign word_len  = RX_D[31:0];

  // A start-of-frame in the middle of a payload aborts that frame; any word
  // arriving on the same cycle is then decoded as if we were already idle.
  assign abort     = RX_SOF && (state_reg == S_PLD);
  assign eff_state = abort ? S_IDLE : state_reg;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= S_IDLE;
      togo_reg  <= '0;
    end else begin
      state_reg <= state_next;
      togo_reg  <= togo_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = eff_state;
    togo_next  = abort ? 32'd0 : togo_reg;
    if (RX_VALID) begin
      case (eff_state)
        S_PLD: begin
          togo_next = togo_reg - 32'd1;
          if (togo_reg == 32'd1) state_next = S_IDLE;
        end
        default: begin
          if (word_type == TYPE_HDR) begin
            state_next = S_HDR;
          end else if (word_type == TYPE_LEN && word_len != 32'd0) begin
            state_next = S_PLD;
            togo_next  = word_len;
          end else begin
            state_next = S_IDLE;
          end
        end
      endcase
    end
  end

  // ---------------- FSM: outputs / actions ----------------
  always_comb begin
    hdr_load     = 1'b0;
    push_req     = 1'b0;
    push_last    = 1'b0;
    frame_inc    = 1'b0;
    illegal_word = 1'b0;
    if (RX_VALID) begin
      case (eff_state)
        S_PLD: begin
          push_req  = 1'b1;
          push_last = (togo_reg == 32'd1);
          frame_inc = (togo_reg == 32'd1);
        end
        default: begin
          if (word_type == TYPE_HDR)      hdr_load     = 1'b1;
          else if (word_type == TYPE_LEN) frame_inc    = (word_len == 32'd0);
          else                            illegal_word = 1'b1;
        end
      endcase
    end
  end

  // ---------------- header, counters, flags ----------------
  logic [63:0] hdr_q_reg;
  logic        hdr_stb_reg;
  logic [15:0] frame_cnt_reg, err_cnt_reg, err_add;
  logic        ovf_reg, bp_reg;

  // An abort and an illegal word on the same cycle are two separate errors.
  assign err_add = {15'd0, abort} + {15'd0, illegal_word};

  // ---------------- payload FIFO ----------------
  logic [64:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]  count_reg, count_next;
  logic [64:0]    head_reg, wr_word;
  logic           push, pop, full;

  assign full    = (count_reg == FULL_LVL);
  assign pop     = (count_reg != '0) && P_READY;
  // A full FIFO still accepts a word when the head leaves on the same cycle.
  assign push    = push_req && (!full || pop);
  assign wr_word = {push_last, RX_D};
  assign rd_ptr_next = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_reg] <= wr_word;
  end

  // head_reg is a registered read of the next head location. When the word
  // being written this cycle becomes the head (FIFO empty or draining its
  // last entry), it is forwarded directly so it appears one cycle later.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      if (count_next == '0)
        head_reg <= '0;
      else if (push && (wr_ptr_reg == rd_ptr_next))
        head_reg <= wr_word;
      else
        head_reg <= mem[rd_ptr_next];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hdr_q_reg     <= '0;
      hdr_stb_reg   <= 1'b0;
      frame_cnt_reg <= '0;
      err_cnt_reg   <= '0;
      ovf_reg       <= 1'b0;
      bp_reg        <= 1'b0;
    end else begin
      hdr_stb_reg   <= hdr_load;
      if (hdr_load) hdr_q_reg <= RX_D;
      frame_cnt_reg <= frame_cnt_reg + {15'd0, frame_inc};
      err_cnt_reg   <= err_cnt_reg + err_add;
      if (push_req && full && !pop) ovf_reg <= 1'b1;
      // Built from the post-update occupancy so RX_BP rises on the cycle
      // right after the write that reaches the threshold.
      bp_reg        <= (count_next >= BP_LVL);
    end
  end

  assign RX_BP     = bp_reg;
  assign HDR_Q     = hdr_q_reg;
  assign HDR_STB   = hdr_stb_reg;
  assign P_DATA    = head_reg[63:0];
  assign P_LAST    = head_reg[64];
  assign P_VALID   = (count_reg != '0);
  assign FRAME_CNT = frame_cnt_reg;
  assign ERR_CNT   = err_cnt_reg;
  assign OVF       = ovf_reg;

endmodule

// File: tb/tb_router_pe_rx.sv
module tb_router_pe_rx;

  localparam int DEPTH = 32;
  localparam int SKID  = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [63:0] RX_D = '0;
  logic        RX_VALID = 1'b0;
  logic        RX_SOF = 1'b0;
  logic        P_READY = 1'b0;
  logic        RX_BP, HDR_STB, P_LAST, P_VALID, OVF;
  logic [63:0] HDR_Q, P_DATA;
  logic [15:0] FRAME_CNT, ERR_CNT;

  router_pe_rx #(.DEPTH(DEPTH), .SKID(SKID)) dut (
    .CLK(CLK), .RST(RST), .RX_D(RX_D), .RX_VALID(RX_VALID), .RX_SOF(RX_SOF),
    .RX_BP(RX_BP), .HDR_Q(HDR_Q), .HDR_STB(HDR_STB), .P_DATA(P_DATA),
    .P_LAST(P_LAST), .P_VALID(P_VALID), .P_READY(P_READY),
    .FRAME_CNT(FRAME_CNT), .ERR_CNT(ERR_CNT), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [64:0] sb [$];   // expected {last, data} payload words, in order
  logic [63:0] hq [$];   // expected header words, in order

  typedef struct {
    logic [63:0] d;
    logic        v;
    logic        sof;
    logic        push;   // word expected to reach P_DATA
    logic        last;   // expected P_LAST of that word
    logic        hdr;    // word expected to produce an HDR_STB pulse
    logic [15:0] fcnt;   // FRAME_CNT after the edge
    logic [15:0] ecnt;   // ERR_CNT after the edge
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [63:0] d, input logic v, input logic s);
    RX_D = d;
    RX_VALID = v;
    RX_SOF = s;
  endtask

  task automatic add(input logic [63:0] d, input logic v, input logic s, input logic p,
                     input logic l, input logic h, input logic [15:0] f, input logic [15:0] e);
    vec_t r;
    r.d = d; r.v = v; r.sof = s; r.push = p; r.last = l; r.hdr = h; r.fcnt = f; r.ecnt = e;
    vecs.push_back(r);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      cyc();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: %0d payload words still expected, required 0", name, sb.size());
    end
  endtask

  // Output monitor: samples on the falling edge, away from the active edge.
  logic [64:0] exp_w;
  logic [63:0] exp_h;
  always @(negedge CLK) begin
    if (!RST) begin
      if (HDR_STB) begin
        if (hq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL hdr_unexpected: got HDR_STB with HDR_Q %h, required no pulse", HDR_Q);
        end else begin
          exp_h = hq.pop_front();
          chk("hdr_q", {1'b0, HDR_Q}, {1'b0, exp_h});
          $display("header %h", HDR_Q);
        end
      end
      if (P_VALID && P_READY) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pld_unexpected: got P_DATA %h last %b, required no word", P_DATA, P_LAST);
        end else begin
          exp_w = sb.pop_front();
          chk("payload", {P_LAST, P_DATA}, exp_w);
          $display("payload %h last %b", P_DATA, P_LAST);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w;

    //      data                    v  sof push last hdr frame err
    add(64'h0100_0000_0000_00AA, 1, 0, 0, 0, 1, 0, 0);
    add(64'h0100_0000_0000_00BB, 1, 0, 0, 0, 1, 0, 0);
    add(64'h0000_0000_0000_0003, 1, 0, 0, 0, 0, 0, 0);
    add(64'hD0D0_0000_0000_0000, 1, 0, 1, 0, 0, 0, 0);
    add(64'hD1D1_0000_0000_0001, 1, 0, 1, 0, 0, 0, 0);
    add(64'hD2D2_0000_0000_0002, 1, 0, 1, 1, 0, 1, 0);
    add(64'h0000_0000_0000_0000, 1, 0, 0, 0, 0, 2, 0);   // N=0
    add(64'h0000_0000_0000_0005, 1, 0, 0, 0, 0, 2, 0);
    add(64'hE0E0_0000_0000_0000, 1, 0, 1, 0, 0, 2, 0);
    add(64'hE1E1_0000_0000_0001, 1, 0, 1, 0, 0, 2, 0);
    add(64'h0000_0000_0000_0001, 1, 1, 0, 0, 0, 2, 1);   // abort + fresh N=1
    add(64'hF0F0_0000_0000_0000, 1, 0, 1, 1, 0, 3, 1);
    add(64'h0200_0000_0000_0000, 1, 0, 0, 0, 0, 3, 2);   // illegal type
    add(64'h0000_0000_0000_0001, 0, 1, 0, 0, 0, 3, 2);   // SOF in IDLE, no valid
    add(64'h0100_0000_0000_00CC, 1, 0, 0, 0, 1, 3, 2);
    add(64'h0100_0000_0000_00EE, 0, 1, 0, 0, 0, 3, 2);   // SOF in HDR, no valid
    add(64'h0000_0000_0000_0001, 1, 0, 0, 0, 0, 3, 2);
    add(64'h6060_0000_0000_0000, 1, 0, 1, 1, 0, 4, 2);
    add(64'h0000_0000_0000_0002, 1, 0, 0, 0, 0, 4, 2);
    add(64'h7070_0000_0000_0000, 1, 0, 1, 0, 0, 4, 2);
    add(64'h0000_0000_0000_0007, 0, 0, 0, 0, 0, 4, 2);   // gap inside payload
    add(64'h7171_0000_0000_0001, 1, 0, 1, 1, 0, 5, 2);

    // Reset state
    RST = 1'b1;
    cyc();
    cyc();
    chk("rst_rx_bp",   {64'd0, RX_BP},   65'd0);
    chk("rst_p_valid", {64'd0, P_VALID}, 65'd0);
    chk("rst_p_last",  {64'd0, P_LAST},  65'd0);
    chk("rst_hdr_stb", {64'd0, HDR_STB}, 65'd0);
    chk("rst_hdr_q",   {1'b0, HDR_Q},    65'd0);
    chk("rst_p_data",  {1'b0, P_DATA},   65'd0);
    chk("rst_frame",   {49'd0, FRAME_CNT}, 65'd0);
    chk("rst_err",     {49'd0, ERR_CNT},   65'd0);
    chk("rst_ovf",     {64'd0, OVF},     65'd0);
    RST = 1'b0;
    P_READY = 1'b1;

    // Table-driven decode sequence
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].d, vecs[i].v, vecs[i].sof);
      if (vecs[i].push) sb.push_back({vecs[i].last, vecs[i].d});
      if (vecs[i].hdr)  hq.push_back(vecs[i].d);
      cyc();
      chk($sformatf("frame_cnt_row%0d", i), {49'd0, FRAME_CNT}, {49'd0, vecs[i].fcnt});
      chk($sformatf("err_cnt_row%0d", i),   {49'd0, ERR_CNT},   {49'd0, vecs[i].ecnt});
    end
    drive(64'd0, 0, 0);
    wait_drain("table_drain");
    cyc();
    chk("table_p_valid_idle", {64'd0, P_VALID}, 65'd0);

    // Overflow / backpressure: N=40 with P_READY=0, ignoring RX_BP
    P_READY = 1'b0;
    drive(64'h0000_0000_0000_0028, 1, 0);
    cyc();
    for (int i = 1; i <= 40; i++) begin
      w = {32'hA5A5_0000, 32'(i)};
      drive(w, 1, 0);
      if (i <= DEPTH) sb.push_back({(i == 40), w});
      cyc();
      chk($sformatf("rx_bp_after_write%0d", i), {64'd0, RX_BP}, {64'd0, (i >= DEPTH - SKID)});
    end
    drive(64'd0, 0, 0);
    cyc();
    cyc();
    chk("ovf_set",      {64'd0, OVF},     65'd1);
    chk("ovf_frame",    {49'd0, FRAME_CNT}, {49'd0, 16'd6});
    chk("ovf_p_valid",  {64'd0, P_VALID}, 65'd1);
    chk("hold_head",    {P_LAST, P_DATA}, sb[0]);

    // Push into a full FIFO with a concurrent pop must be accepted
    drive(64'h0000_0000_0000_0001, 1, 0);
    cyc();
    P_READY = 1'b1;
    drive(64'hBEEF_0000_0000_0099, 1, 0);
    sb.push_back({1'b1, 64'hBEEF_0000_0000_0099});
    cyc();
    drive(64'd0, 0, 0);
    chk("full_pushpop_frame", {49'd0, FRAME_CNT}, {49'd0, 16'd7});
    wait_drain("overflow_drain");
    cyc();
    chk("drain_p_valid", {64'd0, P_VALID}, 65'd0);
    chk("drain_rx_bp",   {64'd0, RX_BP},   65'd0);

    // Reset mid-payload: N=7, three words queued (TOGO=4)
    P_READY = 1'b0;
    drive(64'h0000_0000_0000_0007, 1, 0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      drive({32'hC0DE_0000, 32'(i)}, 1, 0);
      cyc();
    end
    RST = 1'b1;
    P_READY = 1'b1;
    drive(64'h0100_0000_0000_00DD, 1, 1);
    cyc();
    RST = 1'b0;
    drive(64'd0, 0, 0);
    chk("mid_rst_p_valid", {64'd0, P_VALID}, 65'd0);
    chk("mid_rst_rx_bp",   {64'd0, RX_BP},   65'd0);
    chk("mid_rst_frame",   {49'd0, FRAME_CNT}, 65'd0);
    chk("mid_rst_err",     {49'd0, ERR_CNT},   65'd0);
    chk("mid_rst_ovf",     {64'd0, OVF},     65'd0);
    chk("mid_rst_hdr_stb", {64'd0, HDR_STB}, 65'd0);
    chk("mid_rst_hdr_q",   {1'b0, HDR_Q},    65'd0);

    // Fresh frame N=2 after reset
    drive(64'h0000_0000_0000_0002, 1, 0);
    cyc();
    drive(64'h1111_0000_0000_0000, 1, 0);
    sb.push_back({1'b0, 64'h1111_0000_0000_0000});
    cyc();
    drive(64'h2222_0000_0000_0001, 1, 0);
    sb.push_back({1'b1, 64'h2222_0000_0000_0001});
    cyc();
    drive(64'd0, 0, 0);
    chk("post_rst_frame", {49'd0, FRAME_CNT}, {49'd0, 16'd1});
    chk("post_rst_err",   {49'd0, ERR_CNT},   65'd0);
    wait_drain("post_rst_drain");
    cyc();
    chk("hdr_queue_empty", {33'd0, 32'(hq.size())}, 65'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
